des_subkey_gen: RTL and testbench

//  Sequential DES key schedule feeding the round datapath (the S-box ROM stage).

---
 rtl/des_subkey_gen.sv | 160 ++++++++++++++++
 tb/tb_des_subkey_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_subkey_gen.sv
// rtl/des_subkey_gen.sv - sequential DES key schedule, one 48-bit subkey per handshake
// Optional macro DES_KEY_PARITY_CHECK_EN adds parity_err and rejects keys with an even-parity byte.
module des_subkey_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        parity_err
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  // FIPS tables, entries are 1-based bit numbers with bit 1 = MSB
  localparam int pc1_tab [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int pc2_tab [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-pc1_tab[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-pc2_tab[i]];
    return r;
  endfunction

  // Decrypt starts at C16D16 == C0D0, so its first step rotates by zero
  function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic dec);
    if (idx == 4'd0)
      return dec ? 2'd0 : 2'd1;
    else if (idx == 4'd1 || idx == 4'd8 || idx == 4'd15)
      return 2'd1;
    else
      return 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic right,
                                        input logic [1:0] n);
    case ({right, n})
      3'b001:  return {x[26:0], x[27]};
      3'b010:  return {x[25:0], x[27:26]};
      3'b101:  return {x[0], x[27:1]};
      3'b110:  return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, d_q;
  logic [3:0]  round_q;
  logic        dec_q;
  logic        done_q;
  logic        key_ok;
  logic        load, advance, finish;
  logic [55:0] key_pc1;
  logic [1:0]  load_amt, step_amt;

`ifdef DES_KEY_PARITY_CHECK_EN
  always_comb begin
    key_ok = 1'b1;
    for (int b = 0; b < 8; b++)
      if (!(^key[8*b +: 8])) key_ok = 1'b0;
  end
`else
  assign key_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && key_ok) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_pc1  = pc1(key);
  assign load_amt = shift_amt(4'd0, decrypt);
  assign step_amt = shift_amt(round_q + 4'd1, dec_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      if (load) begin
        c_q     <= rot28(key_pc1[55:28], decrypt, load_amt);
        d_q     <= rot28(key_pc1[27:0], decrypt, load_amt);
        dec_q   <= decrypt;
        round_q <= 4'd0;
      end else if (advance) begin
        c_q     <= rot28(c_q, dec_q, step_amt);
        d_q     <= rot28(d_q, dec_q, step_amt);
        round_q <= round_q + 4'd1;
      end
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      parity_err <= 1'b0;
    else
      parity_err <= (state_q == IDLE) && start && !key_ok;
  end
`endif

  assign busy         = (state_q == RUN);
  assign subkey_valid = (state_q == RUN);
  assign subkey       = pc2({c_q, d_q});
  assign round        = round_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_subkey_gen.sv
// tb/tb_des_subkey_gen.sv - randomized self-checking bench for des_subkey_gen
// Reference subkeys come from cumulative-shift DES key schedule arithmetic on bit arrays.
module tb_des_subkey_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        busy;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        parity_err;
`endif

  des_subkey_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .busy         (busy),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round        (round),
    .done         (done)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [63:0] test_key = 64'h133457799BBCDFF1;

  localparam int pc1_t [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int pc2_t [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int shifts [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Standard key schedule: Kn uses C0/D0 left-rotated by the sum of the first n shifts
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
    logic kb [1:64];
    logic cd [0:55];
    logic [47:0] r;
    int tot;
    for (int i = 1; i <= 64; i++) kb[i] = k[64-i];
    tot = 0;
    for (int j = 0; j < n; j++) tot += shifts[j];
    for (int j = 0; j < 28; j++) begin
      cd[j]    = kb[pc1_t[(j + tot) % 28]];
      cd[28+j] = kb[pc1_t[28 + (j + tot) % 28]];
    end
    for (int j = 0; j < 48; j++) r[47-j] = cd[pc2_t[j]-1];
    return r;
  endfunction

  function automatic logic [63:0] odd_parity(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) r[8*b] = ~(^r[8*b+1 +: 7]);
    return r;
  endfunction

  // mode 0: ready always high, 1: random ready, 2: ready low 5 cycles at round 3
  task automatic run_sched(input logic [63:0] k, input logic dec, input int mode,
                           input logic inject, input logic back2back,
                           output logic [47:0] first_sk, output logic [47:0] last_sk,
                           output int vcycles);
    int hs, cyc, stall;
    logic injected;
    if (!back2back) @(negedge clk);
    key = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0; cyc = 0; stall = 0; injected = 1'b0;
    first_sk = '0; last_sk = '0;
    while (hs < 16 && cyc < 300) begin
      key     = {$urandom, $urandom};
      decrypt = 1'($urandom);
      start   = inject && hs == 5 && !injected;
      if (start) injected = 1'b1;
      case (mode)
        0: subkey_ready = 1'b1;
        1: subkey_ready = ($urandom_range(0, 99) < 70);
        default: begin
          if (hs == 3 && stall < 5) begin
            subkey_ready = 1'b0;
            stall++;
          end else subkey_ready = 1'b1;
        end
      endcase
      check("valid", 64'(subkey_valid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("done_early", 64'(done), 64'd0);
      check("round", 64'(round), 64'(hs));
      check("subkey", 64'(subkey), 64'(ref_subkey(k, dec ? 16 - hs : hs + 1)));
`ifdef DES_KEY_PARITY_CHECK_EN
      check("parity_err_run", 64'(parity_err), 64'd0);
`endif
      if (hs == 0) first_sk = subkey;
      if (hs == 15) last_sk = subkey;
      if (subkey_ready) hs++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    vcycles = cyc;
    check("handshakes", 64'(hs), 64'd16);
    check("done_pulse", 64'(done), 64'd1);
    check("valid_end", 64'(subkey_valid), 64'd0);
    check("busy_end", 64'(busy), 64'd0);
    check("round_hold", 64'(round), 64'd15);
    check("subkey_hold", 64'(subkey), 64'(ref_subkey(k, dec ? 1 : 16)));
  endtask

  logic [47:0] f_sk, l_sk, e_first, e_last;
  int vc, cyc;
  logic done_seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key = '0; subkey_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_round", 64'(round), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
    check("rst_parity_err", 64'(parity_err), 64'd0);
`endif
    rst_n = 1'b1;

    run_sched(test_key, 1'b0, 0, 1'b0, 1'b0, f_sk, l_sk, vc);
    check("t1_k1", 64'(f_sk), 64'h1B02EFFC7072);
    check("t1_k16", 64'(l_sk), 64'hCB3D8B0E17F5);
    check("t1_valid_cycles", 64'(vc), 64'd16);
    e_first = f_sk; e_last = l_sk;

    // decrypt started in the very cycle done pulses
    run_sched(test_key, 1'b1, 0, 1'b0, 1'b1, f_sk, l_sk, vc);
    check("t2_first", 64'(f_sk), 64'hCB3D8B0E17F5);
    check("t2_last", 64'(l_sk), 64'h1B02EFFC7072);

    run_sched(test_key, 1'b0, 2, 1'b0, 1'b0, f_sk, l_sk, vc);
    check("t3_cycles", 64'(vc), 64'd21);

    run_sched(test_key, 1'b0, 0, 1'b1, 1'b0, f_sk, l_sk, vc);
    check("t5_first", 64'(f_sk), 64'(e_first));
    check("t5_last", 64'(l_sk), 64'(e_last));

    // abort mid-schedule
    @(negedge clk);
    key = test_key; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (round != 4'd7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_reach_r7", 64'(round), 64'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_valid", 64'(subkey_valid), 64'd0);
    check("t4_subkey", 64'(subkey), 64'd0);
    check("t4_round", 64'(round), 64'd0);
    done_seen = done;
    repeat (20) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    check("t4_no_done", 64'(done_seen), 64'd0);
    run_sched(test_key, 1'b0, 0, 1'b0, 1'b0, f_sk, l_sk, vc);
    check("t4_restart_k1", 64'(f_sk), 64'h1B02EFFC7072);

`ifdef DES_KEY_PARITY_CHECK_EN
    @(negedge clk);
    key = 64'h123457799BBCDFF1; decrypt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_parity_err", 64'(parity_err), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("t6_parity_err_clr", 64'(parity_err), 64'd0);
    check("t6_busy_idle", 64'(busy), 64'd0);
    run_sched(test_key, 1'b0, 0, 1'b0, 1'b0, f_sk, l_sk, vc);
    check("t6_good_k1", 64'(f_sk), 64'h1B02EFFC7072);
`endif

    for (int t = 0; t < 8; t++) begin
      run_sched(odd_parity({$urandom, $urandom}), 1'($urandom), 1, 1'($urandom),
                1'(t % 3 == 2), f_sk, l_sk, vc);
    end

    @(negedge clk);
    check("final_done_low", 64'(done), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
